// File: rtl/alu_cmd_sequencer.sv
// Requester-side driver for a combinational ALU: queues commands, issues them one at a
// time, waits for the ALU to settle, and returns result/carry with the command's tag.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 16,
    parameter int SHW     = 5,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 0,
    parameter int MAX_OP  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shift,
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [3:0]       rsp_tag,
    output logic             rsp_illegal,
    output logic             busy,
    output logic [15:0]      issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 + WIDTH + WIDTH + SHW + 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [3:0] MAX_OP4   = 4'(MAX_OP);
    localparam logic [2:0] LAST_WAIT = 3'(ALU_LAT);

    logic [EW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    logic [1:0]       state;
    logic [2:0]       wait_cnt;

    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [SHW-1:0]   head_shift;
    logic [3:0]       head_tag;
    logic             head_illegal;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign busy      = (state != S_IDLE) || !empty;

    assign {head_op, head_a, head_b, head_shift, head_tag} = mem[rd_ptr[AW-1:0]];
    assign head_illegal = (head_op > MAX_OP4);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Illegal opcodes bypass the ALU entirely and leave its operand registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            alu_opcode   <= '0;
            alu_input1   <= '0;
            alu_input2   <= '0;
            alu_shift    <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_tag      <= '0;
            rsp_illegal  <= 1'b0;
            issued_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rsp_tag <= head_tag;
                        if (head_illegal) begin
                            rsp_result  <= '0;
                            rsp_carry   <= 1'b0;
                            rsp_illegal <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            alu_opcode   <= head_op;
                            alu_input1   <= head_a;
                            alu_input2   <= head_b;
                            alu_shift    <= head_shift;
                            issued_count <= issued_count + 16'd1;
                            wait_cnt     <= '0;
                            state        <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (wait_cnt == LAST_WAIT) begin
                        rsp_result  <= alu_result;
                        rsp_carry   <= alu_carry;
                        rsp_illegal <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a zero-latency instance checked through a response
// scoreboard, plus an ALU_LAT=3 instance fed by a slow ALU model for settle timing.
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 16;
    localparam int SHW   = 5;

    typedef struct packed {
        logic [15:0] result;
        logic        carry;
        logic [3:0]  tag;
        logic        illegal;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [SHW-1:0]   cmd_shift;
    logic [3:0]       cmd_tag;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [SHW-1:0]   alu_shift;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic [3:0]       rsp_tag;
    logic             rsp_illegal;
    logic             busy;
    logic [15:0]      issued_count;

    logic             l3_cmd_valid;
    logic             l3_cmd_ready;
    logic [3:0]       l3_alu_opcode;
    logic [WIDTH-1:0] l3_alu_input1;
    logic [WIDTH-1:0] l3_alu_input2;
    logic [SHW-1:0]   l3_alu_shift;
    logic [WIDTH-1:0] l3_alu_result;
    logic             l3_alu_carry;
    logic             l3_rsp_valid;
    logic             l3_rsp_ready;
    logic [WIDTH-1:0] l3_rsp_result;
    logic             l3_rsp_carry;
    logic [3:0]       l3_rsp_tag;
    logic             l3_rsp_illegal;
    logic             l3_busy;
    logic [15:0]      l3_issued_count;
    logic [16:0]      slow_p1;
    logic [16:0]      slow_p2;
    logic [16:0]      slow_p3;

    rsp_t exp_q[$];
    rsp_t sb_exp;
    int   n_compared = 0;
    int   n_mismatch = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(4), .ALU_LAT(0), .MAX_OP(10)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
        .busy(busy), .issued_count(issued_count)
    );

    alu_cmd_sequencer #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(4), .ALU_LAT(3), .MAX_OP(10)) dut_lat3 (
        .clk(clk), .rst(rst),
        .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(l3_alu_opcode), .alu_input1(l3_alu_input1), .alu_input2(l3_alu_input2),
        .alu_shift(l3_alu_shift), .alu_result(l3_alu_result), .alu_carry(l3_alu_carry),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_result(l3_rsp_result),
        .rsp_carry(l3_rsp_carry), .rsp_tag(l3_rsp_tag), .rsp_illegal(l3_rsp_illegal),
        .busy(l3_busy), .issued_count(l3_issued_count)
    );

    // Stand-in ALU: op 0 rotate-left, op 4 subtract with borrow as carry, anything else add.
    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [4:0] sh);
        logic [15:0] r;
        logic [3:0]  s;
        s = sh[3:0];
        case (op)
            4'd0:    begin r = (a << s) | (a >> (5'd16 - {1'b0, s})); return {1'b0, r}; end
            4'd4:    return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_model(alu_opcode, alu_input1, alu_input2, alu_shift);

    // Slow ALU: the correct value only reaches the output three edges after operands change.
    always @(posedge clk) begin
        slow_p1 <= alu_model(l3_alu_opcode, l3_alu_input1, l3_alu_input2, l3_alu_shift);
        slow_p2 <= slow_p1;
        slow_p3 <= slow_p2;
    end
    assign {l3_alu_carry, l3_alu_result} = slow_p3;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The handshake completes on the coming rising edge, so compare at the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL unexpected_rsp: got tag 0x%0h, expected no response", rsp_tag);
            end else begin
                sb_exp = exp_q.pop_front();
                checkOutput("rsp_tag", 32'(rsp_tag), 32'(sb_exp.tag));
                checkOutput("rsp_result", 32'(rsp_result), 32'(sb_exp.result));
                checkOutput("rsp_carry", 32'(rsp_carry), 32'(sb_exp.carry));
                checkOutput("rsp_illegal", 32'(rsp_illegal), 32'(sb_exp.illegal));
            end
        end
    end

    // Returns 1ns after the edge on which the command was accepted.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] sh, input logic [3:0] tag,
                                 input logic [15:0] exp_res, input logic exp_c,
                                 input logic exp_ill, input bit do_expect);
        bit accepted;
        rsp_t e;
        accepted   = 1'b0;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shift  = sh;
        cmd_tag    = tag;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            if (do_expect) begin
                e.result  = exp_res;
                e.carry   = exp_c;
                e.tag     = tag;
                e.illegal = exp_ill;
                exp_q.push_back(e);
            end
            #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        l3_cmd_valid = 1'b0;
        cmd_opcode   = '0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_shift    = '0;
        cmd_tag      = '0;
        rsp_ready    = 1'b1;
        l3_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_issued", 32'(issued_count), 32'd0);
        checkOutput("reset_alu_input1", 32'(alu_input1), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A legal op popped at edge E drives the ALU right after E; with no extra
        // latency the response is visible after the following edge.
        applyStimulus(4'd0, 16'h8001, 16'h0000, 5'd1, 4'd3, 16'h0003, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t1_valid_early", 32'(rsp_valid), 32'd0);
        checkOutput("t1_alu_input1", 32'(alu_input1), 32'h8001);
        checkOutput("t1_alu_shift", 32'(alu_shift), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t1_issued", 32'(issued_count), 32'd1);
        waitIdle();

        applyStimulus(4'd4, 16'h0005, 16'h0007, 5'd0, 4'd9, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        waitIdle();
        checkOutput("t2_issued", 32'(issued_count), 32'd2);

        // Illegal opcode: response one edge after the pop, ALU registers untouched.
        applyStimulus(4'hF, 16'h1234, 16'h5678, 5'd2, 4'd7, 16'h0000, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t3_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t3_illegal", 32'(rsp_illegal), 32'd1);
        checkOutput("t3_alu_opcode", 32'(alu_opcode), 32'd4);
        checkOutput("t3_alu_input1", 32'(alu_input1), 32'h0005);
        checkOutput("t3_alu_input2", 32'(alu_input2), 32'h0007);
        checkOutput("t3_issued", 32'(issued_count), 32'd2);
        waitIdle();

        // Back-pressure: tag 1 parks in RESP, tags 2..5 fill the FIFO, tag 6 stalls.
        rsp_ready = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            applyStimulus(4'd2, 16'(16'hFFF0 + t), 16'h0010, 5'd0, 4'(t), 16'(t), 1'b1, 1'b0, 1'b1);
        end
        checkOutput("t4_cmd_ready_full", 32'(cmd_ready), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        cmd_opcode = 4'd2;
        cmd_a      = 16'hFFF6;
        cmd_b      = 16'h0010;
        cmd_tag    = 4'd6;
        cmd_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("t4_stall_ready", 32'(cmd_ready), 32'd0);
            checkOutput("t4_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("t4_hold_tag", 32'(rsp_tag), 32'd1);
            checkOutput("t4_hold_result", 32'(rsp_result), 32'd1);
        end
        rsp_ready = 1'b1;
        applyStimulus(4'd2, 16'hFFF6, 16'h0010, 5'd0, 4'd6, 16'h0006, 1'b1, 1'b0, 1'b1);
        waitIdle();
        checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("t4_issued", 32'(issued_count), 32'd8);

        // Reset while the op is in DRIVE: it must vanish without a response.
        applyStimulus(4'd4, 16'h0100, 16'h0001, 5'd0, 4'hA, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t5_in_drive", 32'(alu_input1), 32'h0100);
        checkOutput("t5_no_rsp_yet", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_issued", 32'(issued_count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(4'd4, 16'h0010, 16'h0003, 5'd0, 4'hC, 16'h000D, 1'b0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("t5_issued_after", 32'(issued_count), 32'd1);
        checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

        // ALU_LAT=3: response appears after four edges past the pop edge, carrying the settled value.
        cmd_opcode   = 4'd4;
        cmd_a        = 16'h0009;
        cmd_b        = 16'h0002;
        cmd_shift    = 5'd0;
        cmd_tag      = 4'd5;
        l3_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        l3_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t6_alu_input1", 32'(l3_alu_input1), 32'h0009);
        for (int k = 1; k <= 3; k++) begin
            checkOutput("t6_valid_early", 32'(l3_rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("t6_valid_early", 32'(l3_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t6_valid", 32'(l3_rsp_valid), 32'd1);
        checkOutput("t6_result", 32'(l3_rsp_result), 32'h0007);
        checkOutput("t6_carry", 32'(l3_rsp_carry), 32'd0);
        checkOutput("t6_tag", 32'(l3_rsp_tag), 32'd5);
        checkOutput("t6_illegal", 32'(l3_rsp_illegal), 32'd0);
        checkOutput("t6_issued", 32'(l3_issued_count), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t6_valid_drop", 32'(l3_rsp_valid), 32'd0);
        checkOutput("t6_busy", 32'(l3_busy), 32'd0);
        checkOutput("t6_cmd_ready", 32'(l3_cmd_ready), 32'd1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
